// File: rtl/nx_axi4s_pkg.sv
// nx_axi4s_pkg: shared slot geometry and packer state encoding for the Nexus/AXI4-stream bridge.
package nx_axi4s_pkg;
  localparam int SLOT_W  = 32;
  localparam int MSG_W   = 31;
  localparam int VLD_BIT = 31;
  typedef enum logic {FILL, SEND} pk_state_e;
endpackage

// File: rtl/nx_axi4s_packer.sv
// nx_axi4s_packer: packs Nexus messages into AXI4-stream beats, closing a beat when full or after an idle timeout.
module nx_axi4s_packer
  import nx_axi4s_pkg::*;
#(
  parameter int SLOTS        = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [MSG_W-1:0]        i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [SLOTS*SLOT_W-1:0] o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    i_tready,
  output logic                    o_empty
);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int IW = $clog2(SLOTS);
  localparam int TW = FLUSH_CYCLES < 2 ? 1 : $clog2(FLUSH_CYCLES + 1);
  pk_state_e                     state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [SLOTS-1:0][SLOT_W-1:0]  slots_q, slots_d;
  logic                          tlast_q, tlast_d;
  logic                          run_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    slots_d = slots_q;
    tlast_d = tlast_q;
    o_ready = run_q && state_q == FILL;
    if (state_q == SEND) begin
      if (i_tready) begin
        state_d = FILL;
        count_d = '0;
        timer_d = '0;
        slots_d = '0;
        tlast_d = 1'b0;
      end
    end else if (o_ready && i_valid) begin
      // an accept always beats a timeout landing in the same cycle
      slots_d[count_q[IW-1:0]][VLD_BIT]     = 1'b1;
      slots_d[count_q[IW-1:0]][MSG_W-1:0]   = i_data;
      count_d = count_q + 1'b1;
      timer_d = '0;
      state_d = count_d == CW'(SLOTS) ? SEND : FILL;
    end else if (count_q != '0 && FLUSH_CYCLES != 0) begin
      timer_d = timer_q + 1'b1;
      if (timer_d == TW'(FLUSH_CYCLES)) begin
        state_d = SEND;
        tlast_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= FILL;
      count_q <= '0;
      timer_q <= '0;
      slots_q <= '0;
      tlast_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      slots_q <= slots_d;
      tlast_q <= tlast_d;
      run_q   <= 1'b1;
    end
  end
  assign o_tdata  = slots_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = state_q == SEND;
  assign o_empty  = state_q == FILL && count_q == '0;
endmodule

// File: rtl/nx_axi4s_bridge_gen2.sv
// nx_axi4s_bridge_gen2: bidirectional bridge between slot-packed AXI4-stream beats and single Nexus messages.
module nx_axi4s_bridge_gen2
  import nx_axi4s_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [AXI4_DATA_WIDTH-1:0] i_ib_axi4s_tdata,
  input  logic                       i_ib_axi4s_tlast,
  input  logic                       i_ib_axi4s_tvalid,
  output logic                       o_ib_axi4s_tready,
  output logic [MSG_W-1:0]           o_ob_nx_data,
  output logic                       o_ob_nx_valid,
  input  logic                       i_ob_nx_ready,
  input  logic [MSG_W-1:0]           i_ib_nx_data,
  input  logic                       i_ib_nx_valid,
  output logic                       o_ib_nx_ready,
  output logic [AXI4_DATA_WIDTH-1:0] o_ob_axi4s_tdata,
  output logic                       o_ob_axi4s_tlast,
  output logic                       o_ob_axi4s_tvalid,
  input  logic                       i_ob_axi4s_tready,
  output logic                       o_idle
);
  localparam int SLOTS = AXI4_DATA_WIDTH / SLOT_W;
  localparam int IW    = $clog2(SLOTS);
  logic [SLOTS-1:0]              mask_q, mask_d;
  logic [SLOTS-1:0][MSG_W-1:0]   msg_q, msg_d;
  logic [SLOTS-1:0][SLOT_W-1:0]  beat;
  logic [IW-1:0]                 idx;
  logic                          run_q, pk_empty, unused_tlast;
  assign beat         = i_ib_axi4s_tdata;
  assign unused_tlast = i_ib_axi4s_tlast;
  // mask_q holds the still-pending valid slots; the register is empty once it drains
  always_comb begin
    idx    = '0;
    mask_d = mask_q;
    msg_d  = msg_q;
    for (int s = SLOTS - 1; s >= 0; s--) if (mask_q[s]) idx = IW'(s);
    if (o_ib_axi4s_tready && i_ib_axi4s_tvalid) begin
      for (int s = 0; s < SLOTS; s++) begin
        mask_d[s] = beat[s][VLD_BIT];
        msg_d[s]  = beat[s][MSG_W-1:0];
      end
    end else if (o_ob_nx_valid && i_ob_nx_ready) begin
      mask_d[idx] = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mask_q <= '0;
      msg_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      msg_q  <= msg_d;
      run_q  <= 1'b1;
    end
  end
  assign o_ib_axi4s_tready = run_q && mask_q == '0;
  assign o_ob_nx_valid     = |mask_q;
  assign o_ob_nx_data      = msg_q[idx];
  assign o_idle            = mask_q == '0 && pk_empty;
  nx_axi4s_packer #(.SLOTS(SLOTS), .FLUSH_CYCLES(FLUSH_CYCLES)) u_packer (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_data   (i_ib_nx_data),
    .i_valid  (i_ib_nx_valid),
    .o_ready  (o_ib_nx_ready),
    .o_tdata  (o_ob_axi4s_tdata),
    .o_tlast  (o_ob_axi4s_tlast),
    .o_tvalid (o_ob_axi4s_tvalid),
    .i_tready (i_ob_axi4s_tready),
    .o_empty  (pk_empty)
  );
endmodule

// File: tb/tb_nx_axi4s_bridge_gen2.sv
// tb_nx_axi4s_bridge_gen2: directed vectors for unpacking plus hand-written packer, timeout and reset sequences.
module tb_nx_axi4s_bridge_gen2;
  logic         clk, rstn;
  logic [127:0] ib_tdata;
  logic         ib_tlast, ib_tvalid, ib_tready;
  logic [30:0]  ob_nx_data, ib_nx_data;
  logic         ob_nx_valid, ob_nx_ready, ib_nx_valid, ib_nx_ready;
  logic [127:0] ob_tdata;
  logic         ob_tlast, ob_tvalid, ob_tready, idle;
  int checks = 0, failures = 0;

  typedef struct {
    logic [127:0] beat;
    int           n;
    logic [30:0]  m [4];
  } vec_t;
  vec_t vt [4];

  nx_axi4s_bridge_gen2 #(.AXI4_DATA_WIDTH(128), .FLUSH_CYCLES(16)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ib_axi4s_tdata(ib_tdata), .i_ib_axi4s_tlast(ib_tlast),
    .i_ib_axi4s_tvalid(ib_tvalid), .o_ib_axi4s_tready(ib_tready),
    .o_ob_nx_data(ob_nx_data), .o_ob_nx_valid(ob_nx_valid), .i_ob_nx_ready(ob_nx_ready),
    .i_ib_nx_data(ib_nx_data), .i_ib_nx_valid(ib_nx_valid), .o_ib_nx_ready(ib_nx_ready),
    .o_ob_axi4s_tdata(ob_tdata), .o_ob_axi4s_tlast(ob_tlast),
    .o_ob_axi4s_tvalid(ob_tvalid), .i_ob_axi4s_tready(ob_tready),
    .o_idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [30:0] d);
    ib_nx_data  = d;
    ib_nx_valid = 1'b1;
    #1 chk("nx_ready_on_send", ib_nx_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_ib_tready"}, ib_tready, 1'b0);
    chk({tag, "_nx_ready"}, ib_nx_ready, 1'b0);
    chk({tag, "_ob_nx_valid"}, ob_nx_valid, 1'b0);
    chk({tag, "_ob_tvalid"}, ob_tvalid, 1'b0);
    chk({tag, "_ob_tlast"}, ob_tlast, 1'b0);
    chk({tag, "_ob_tdata"}, ob_tdata, 128'h0);
    chk({tag, "_idle"}, idle, 1'b1);
  endtask

  initial begin
    int got, back, j;
    vt[0].beat = {32'h80000044, 32'h80000033, 32'h00000022, 32'h80000011};
    vt[0].n = 3; vt[0].m = '{31'h11, 31'h33, 31'h44, 31'h0};
    vt[1].beat = {32'h7fffffff, 32'h12345678, 32'h00000000, 32'h00000001};
    vt[1].n = 0; vt[1].m = '{31'h0, 31'h0, 31'h0, 31'h0};
    vt[2].beat = {32'hfabcdef0, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[2].n = 1; vt[2].m = '{31'h7abcdef0, 31'h0, 31'h0, 31'h0};
    vt[3].beat = {32'hc0000003, 32'h80000002, 32'h80000001, 32'hffffffff};
    vt[3].n = 4; vt[3].m = '{31'h7fffffff, 31'h1, 31'h2, 31'h40000003};

    rstn = 1'b0; ib_tdata = '0; ib_tlast = 1'b0; ib_tvalid = 1'b0; ob_nx_ready = 1'b1;
    ib_nx_data = '0; ib_nx_valid = 1'b0; ob_tready = 1'b0;
    #1 reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    #1 chk("tready_before_edge", ib_tready, 1'b0);
    @(negedge clk);
    #1 chk("tready_after_edge", ib_tready, 1'b1);
    chk("nx_ready_after_edge", ib_nx_ready, 1'b1);

    // inbound unpack vectors with downstream ready held high
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      ib_tdata = vt[v].beat; ib_tvalid = 1'b1;
      #1 chk($sformatf("v%0d_tready_pre", v), ib_tready, 1'b1);
      @(negedge clk);
      ib_tvalid = 1'b0;
      got = 0; back = -1;
      for (int c = 1; c <= 8; c++) begin
        #1;
        if (ob_nx_valid) begin
          if (got < 4) chk($sformatf("v%0d_msg%0d", v, got), ob_nx_data, vt[v].m[got]);
          chk($sformatf("v%0d_msg%0d_cycle", v, got), c, got + 1);
          got++;
        end
        if (ib_tready && back < 0) back = c;
        @(negedge clk);
      end
      chk($sformatf("v%0d_count", v), got, vt[v].n);
      chk($sformatf("v%0d_tready_back", v), back, vt[v].n + 1);
    end

    // downstream stall holds the presented message
    ib_tdata = {32'h0, 32'h80000bbb, 32'h80000aaa, 32'h0}; ib_tvalid = 1'b1; ob_nx_ready = 1'b0;
    @(negedge clk);
    ib_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_valid", ob_nx_valid, 1'b1);
      chk("stall_data", ob_nx_data, 31'haaa);
      chk("stall_tready", ib_tready, 1'b0);
      @(negedge clk);
    end
    ob_nx_ready = 1'b1;
    #1 chk("stall_rel_a", ob_nx_data, 31'haaa);
    @(negedge clk);
    #1 chk("stall_rel_b", ob_nx_data, 31'hbbb);
    @(negedge clk);
    #1 chk("stall_done_valid", ob_nx_valid, 1'b0);
    chk("stall_done_tready", ib_tready, 1'b1);

    // four back-to-back messages close by full
    @(negedge clk);
    send(31'h1); send(31'h2); send(31'h3); send(31'h4);
    ib_nx_valid = 1'b0;
    #1 chk("full_tvalid", ob_tvalid, 1'b1);
    chk("full_tdata", ob_tdata, {32'h80000004, 32'h80000003, 32'h80000002, 32'h80000001});
    chk("full_tlast", ob_tlast, 1'b0);
    chk("full_nx_ready", ib_nx_ready, 1'b0);
    ob_tready = 1'b1;
    @(negedge clk);
    ob_tready = 1'b0;
    #1 chk("full_done_tvalid", ob_tvalid, 1'b0);
    chk("full_done_nx_ready", ib_nx_ready, 1'b1);
    chk("full_done_idle", idle, 1'b1);

    // two messages then silence close by timeout
    @(negedge clk);
    send(31'h21); send(31'h22);
    ib_nx_valid = 1'b0;
    for (j = 0; j < 40; j++) begin
      #1;
      if (ob_tvalid) break;
      @(negedge clk);
    end
    chk("timeout_latency", j, 16);
    chk("timeout_tdata", ob_tdata, {64'h0, 32'h80000022, 32'h80000021});
    chk("timeout_tlast", ob_tlast, 1'b1);
    ob_tready = 1'b1;
    @(negedge clk);
    ob_tready = 1'b0;
    #1 chk("timeout_done_tvalid", ob_tvalid, 1'b0);

    // a message landing on the expiry cycle wins over the flush
    @(negedge clk);
    send(31'h31); send(31'h32);
    ib_nx_valid = 1'b0;
    for (int c = 0; c < 15; c++) @(negedge clk);
    send(31'h33);
    ib_nx_valid = 1'b0;
    #1 chk("expiry_no_flush", ob_tvalid, 1'b0);
    chk("expiry_nx_ready", ib_nx_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    send(31'h34);
    ib_nx_valid = 1'b0;
    #1 chk("expiry_tvalid", ob_tvalid, 1'b1);
    chk("expiry_tlast", ob_tlast, 1'b0);
    chk("expiry_tdata", ob_tdata, {32'h80000034, 32'h80000033, 32'h80000032, 32'h80000031});
    ob_tready = 1'b1;
    @(negedge clk);
    ob_tready = 1'b0;

    // long outbound backpressure
    @(negedge clk);
    send(31'h41); send(31'h42); send(31'h43); send(31'h44);
    ib_nx_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1 chk("bp_tvalid", ob_tvalid, 1'b1);
      chk("bp_nx_ready", ib_nx_ready, 1'b0);
      chk("bp_tdata", ob_tdata, {32'h80000044, 32'h80000043, 32'h80000042, 32'h80000041});
      @(negedge clk);
    end
    ob_tready = 1'b1;
    @(negedge clk);
    ob_tready = 1'b0;
    #1 chk("bp_done_tvalid", ob_tvalid, 1'b0);
    chk("bp_done_idle", idle, 1'b1);
    chk("bp_done_nx_ready", ib_nx_ready, 1'b1);

    // reset with a partial pack and a half-drained unpack
    @(negedge clk);
    send(31'h51); send(31'h52); send(31'h53);
    ib_nx_valid = 1'b0;
    ib_tdata = {32'h80000064, 32'h80000063, 32'h80000062, 32'h80000061}; ib_tvalid = 1'b1;
    @(negedge clk);
    ib_tvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("pre_rst_drain", ob_nx_data, 31'h63);
    chk("pre_rst_idle", idle, 1'b0);
    rstn = 1'b0;
    #1 reset_outputs("rst1");
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst1_tready_before_edge", ib_tready, 1'b0);
    @(negedge clk);
    #1 chk("rst1_tready_after_edge", ib_tready, 1'b1);
    chk("rst1_nx_ready_after_edge", ib_nx_ready, 1'b1);
    for (int c = 0; c < 30; c++) begin
      #1 chk("post_rst_quiet", {ob_nx_valid, ob_tvalid, idle}, 3'b001);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
